// File: rtl/spmv_pkg.sv
// Shared definitions for the SpMV processing-element control slice:
// opcode values, the PE control state encoding and opcode field positions.
package spmv_pkg;

    localparam logic [6:0] OP_NOP    = 7'd0;
    localparam logic [6:0] OP_RST    = 7'd1;
    localparam logic [6:0] OP_STEADY = 7'd2;
    localparam logic [6:0] OP_LD     = 7'd3;
    localparam logic [6:0] OP_RD     = 7'd4;

    // First bit of the PE-id field; the 7-bit opcode sits below it.
    localparam int OPCODE_ARG_PE = 7;

    typedef enum logic {
        IDLE   = 1'b0,
        STEADY = 1'b1
    } state_t;

    // First bit of the register-index field (broadcast flag sits just below).
    function automatic int arg1_pos(input int id_w);
        return OPCODE_ARG_PE + id_w + 1;
    endfunction

    // First bit of the data field, which runs up to bit 63.
    function automatic int arg2_pos(input int id_w, input int idx_w);
        return arg1_pos(id_w) + idx_w;
    endfunction

endpackage

// File: rtl/spmv_opt_decode.sv
// Combinational opcode decoder for one PE: splits the registered opcode word
// into fields and produces addressed one-hot command strobes.
// The RD strobe exists only when SPMV_PE_CTRL_READBACK_EN is defined.
module spmv_opt_decode
    import spmv_pkg::*;
#(
    parameter  int ID        = 0,
    parameter  int ID_W      = 4,
    parameter  int REG_IDX_W = 4,
    localparam int ARG1      = arg1_pos(ID_W),
    localparam int ARG2      = arg2_pos(ID_W, REG_IDX_W)
) (
    input  logic [63:0]          opt_r,
    output logic [REG_IDX_W-1:0] idx,
    output logic [63-ARG2:0]     data,
    output logic                 busy_req,
    output logic                 do_rst,
    output logic                 do_steady,
`ifdef SPMV_PE_CTRL_READBACK_EN
    output logic                 do_rd,
`endif
    output logic                 do_ld
);

    logic [6:0]      op;
    logic [ID_W-1:0] pe;
    logic            bcast;
    logic            addressed;

    assign op    = opt_r[6:0];
    assign pe    = opt_r[OPCODE_ARG_PE +: ID_W];
    assign bcast = opt_r[ARG1-1];
    assign idx   = opt_r[ARG1 +: REG_IDX_W];
    assign data  = opt_r[63:ARG2];

    assign addressed = bcast | (pe == ID_W'(ID));

    // Any addressed non-NOP opcode (including unknown ones) marks the PE busy.
    assign busy_req  = addressed & (op != OP_NOP);
    assign do_rst    = addressed & (op == OP_RST);
    assign do_steady = addressed & (op == OP_STEADY);
    assign do_ld     = addressed & (op == OP_LD);
`ifdef SPMV_PE_CTRL_READBACK_EN
    // Readback is point-to-point only; a broadcast RD is just forwarded.
    assign do_rd     = addressed & ~bcast & (op == OP_RD);
`endif

endmodule

// File: rtl/spmv_pe_ctrl.sv
// Control front end for one SpMV processing element: opcode bus stage,
// busy chain stage, configuration register file and IDLE/STEADY sequencing
// with a work pointer (reg0) advancing toward the end register (reg1).
// Optional opcode readback is enabled by defining SPMV_PE_CTRL_READBACK_EN.
module spmv_pe_ctrl
    import spmv_pkg::*;
#(
    parameter int ID         = 0,
    parameter int ID_W       = 4,
    parameter int NUM_REGS   = 2,
    parameter int REG_IDX_W  = 4,
    parameter int REG_W      = 48,
    parameter int RST_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [63:0]               opt_in,
    output logic [63:0]               opt_out,
    input  logic                      busy_in,
    output logic                      busy_out,
    input  logic                      step_in,
    output logic                      soft_rst,
    output logic                      steady,
    output logic [NUM_REGS*REG_W-1:0] reg_q
);

    localparam int ARG2   = arg2_pos(ID_W, REG_IDX_W);
    localparam int DATA_W = 64 - ARG2;
    localparam int CNT_W  = $clog2(RST_CYCLES + 1);

    logic [63:0]          opt_r;
    logic [63:0]          opt_out_reg;
    logic [63:0]          opt_next;
    logic                 busy_out_reg;
    logic                 busy_next;
    logic                 soft_rst_reg;
    logic [CNT_W-1:0]     cnt_reg;
    state_t               state_reg;
    state_t               state_next;
    logic [REG_W-1:0]     regs_reg  [NUM_REGS];
    logic [REG_W-1:0]     regs_next [NUM_REGS];

    logic [REG_IDX_W-1:0] dec_idx;
    logic [DATA_W-1:0]    dec_data;
    logic                 dec_busy;
    logic                 dec_rst;
    logic                 dec_steady;
    logic                 dec_ld;
`ifdef SPMV_PE_CTRL_READBACK_EN
    logic                 dec_rd;
    logic [DATA_W-1:0]    rd_val;
`endif

    spmv_opt_decode #(
        .ID        (ID),
        .ID_W      (ID_W),
        .REG_IDX_W (REG_IDX_W)
    ) u_decode (
        .opt_r     (opt_r),
        .idx       (dec_idx),
        .data      (dec_data),
        .busy_req  (dec_busy),
        .do_rst    (dec_rst),
        .do_steady (dec_steady),
`ifdef SPMV_PE_CTRL_READBACK_EN
        .do_rd     (dec_rd),
`endif
        .do_ld     (dec_ld)
    );

    // Next state and register file: step increment, then LD, then RST override.
    always_comb begin
        state_next = state_reg;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_next[i] = regs_reg[i];
        end
        if (state_reg == STEADY) begin
            if (regs_reg[0] == regs_reg[1]) begin
                state_next = IDLE;
            end else if (step_in) begin
                regs_next[0] = regs_reg[0] + REG_W'(1);
            end
        end
        if (dec_ld) begin
            // Out-of-range indices match no register and are dropped.
            for (int i = 0; i < NUM_REGS; i++) begin
                if (dec_idx == REG_IDX_W'(i)) begin
                    regs_next[i] = dec_data[REG_W-1:0];
                end
            end
        end
        if (dec_steady) begin
            state_next = STEADY;
        end
        if (dec_rst) begin
            state_next = IDLE;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_next[i] = '0;
            end
        end
    end

`ifdef SPMV_PE_CTRL_READBACK_EN
    // Readback mux: zero-extended register, or zero for an out-of-range index.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (dec_idx == REG_IDX_W'(i)) begin
                rd_val = DATA_W'(regs_reg[i]);
            end
        end
    end

    // Forwarded opcode, with the data field replaced on a unicast RD.
    always_comb begin
        opt_next = opt_r;
        if (dec_rd) begin
            opt_next[63:ARG2] = rd_val;
        end
    end
`else
    // Forwarded opcode passes through unchanged.
    always_comb begin
        opt_next = opt_r;
    end
`endif

    // Busy is the OR of downstream busy and everything keeping this PE occupied.
    always_comb begin
        busy_next = busy_in | (state_reg == STEADY) | soft_rst_reg | dec_busy;
    end

    // Bus stage, busy stage, state and register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opt_r        <= '0;
            opt_out_reg  <= '0;
            busy_out_reg <= 1'b0;
            state_reg    <= IDLE;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            opt_r        <= opt_in;
            opt_out_reg  <= opt_next;
            busy_out_reg <= busy_next;
            state_reg    <= state_next;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= regs_next[i];
            end
        end
    end

    // Soft-reset pulse: RST (re)loads the count, pulse stays high until it drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg      <= '0;
            soft_rst_reg <= 1'b0;
        end else if (dec_rst) begin
            cnt_reg      <= CNT_W'(RST_CYCLES - 1);
            soft_rst_reg <= 1'b1;
        end else if (cnt_reg != '0) begin
            cnt_reg      <= cnt_reg - CNT_W'(1);
        end else begin
            soft_rst_reg <= 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_q
            assign reg_q[gi*REG_W +: REG_W] = regs_reg[gi];
        end
    endgenerate

    assign opt_out  = opt_out_reg;
    assign busy_out = busy_out_reg;
    assign soft_rst = soft_rst_reg;
    assign steady   = (state_reg == STEADY);

endmodule

// File: tb/tb_spmv_pe_ctrl.sv
// Directed self-checking bench for spmv_pe_ctrl (default parameters, ID=0).
// Readback expectations follow SPMV_PE_CTRL_READBACK_EN when it is defined.
module tb_spmv_pe_ctrl;

    localparam logic [6:0] C_RST    = 7'd1;
    localparam logic [6:0] C_STEADY = 7'd2;
    localparam logic [6:0] C_LD     = 7'd3;
    localparam logic [6:0] C_RD     = 7'd4;
    localparam logic [63:0] NOPD    = 64'hA5A5_0000_0000_0000;

    logic         clk;
    logic         rst_n;
    logic [63:0]  opt_in;
    logic [63:0]  opt_out;
    logic         busy_in;
    logic         busy_out;
    logic         step_in;
    logic         soft_rst;
    logic         steady;
    logic [95:0]  reg_q;

    int n_checks = 0;
    int n_errors = 0;

    spmv_pe_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .opt_in   (opt_in),
        .opt_out  (opt_out),
        .busy_in  (busy_in),
        .busy_out (busy_out),
        .step_in  (step_in),
        .soft_rst (soft_rst),
        .steady   (steady),
        .reg_q    (reg_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; sampling and driving happen 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mk_op(input logic [6:0] op, input logic [3:0] pe,
                                          input logic bc, input logic [3:0] idx,
                                          input logic [47:0] data);
        return {data, idx, bc, pe, op};
    endfunction

    // Present an opcode for one cycle, then wait for the edge that acts on it.
    task automatic send(input logic [63:0] op);
        $display("txn opt_in=%h", op);
        opt_in = op;
        tick();
        opt_in = '0;
        tick();
    endtask

    function automatic logic [63:0] r0();
        return 64'(reg_q[47:0]);
    endfunction

    function automatic logic [63:0] r1();
        return 64'(reg_q[95:48]);
    endfunction

    initial begin
        logic [63:0] op;
        logic [63:0] exp;
        int pulses;

        rst_n   = 1'b0;
        opt_in  = '0;
        busy_in = 1'b0;
        step_in = 1'b0;
        repeat (3) tick();
        check("rst_opt_out", opt_out, 64'h0);
        check("rst_busy", 64'(busy_out), 64'h0);
        check("rst_soft", 64'(soft_rst), 64'h0);
        check("rst_steady", 64'(steady), 64'h0);
        rst_n = 1'b1;
        tick();
        check("idle_regq_lo", r0(), 64'h0);
        check("idle_regq_hi", r1(), 64'h0);

        // Two-cycle bus latency on a NOP carrying data.
        $display("txn opt_in=%h", NOPD);
        opt_in = NOPD;
        tick();
        check("lag1", opt_out, 64'h0);
        opt_in = '0;
        tick();
        check("lag2", opt_out, NOPD);
        check("nop_busy", 64'(busy_out), 64'h0);

        // Program pointer and end, then run three steps.
        op = mk_op(C_LD, 4'd0, 1'b0, 4'd1, 48'd10);
        send(op);
        check("ld_reg1", r1(), 64'd10);
        check("ld_fwd", opt_out, op);
        check("ld_busy", 64'(busy_out), 64'h1);
        send(mk_op(C_LD, 4'd0, 1'b0, 4'd0, 48'd7));
        check("ld_reg0", r0(), 64'd7);
        send(mk_op(C_STEADY, 4'd0, 1'b0, 4'd0, 48'd0));
        check("steady_on", 64'(steady), 64'h1);
        step_in = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("step%0d", k), r0(), 64'(7 + k));
        end
        step_in = 1'b0;
        check("steady_at_end", 64'(steady), 64'h1);
        tick();
        check("steady_drop", 64'(steady), 64'h0);
        check("busy_lag", 64'(busy_out), 64'h1);
        tick();
        check("busy_fall", 64'(busy_out), 64'h0);
        check("end_reg0", r0(), 64'd10);

        // Addressing: other PE ignored, broadcast accepted, both forwarded.
        op = mk_op(C_LD, 4'd1, 1'b0, 4'd0, 48'h55);
        send(op);
        check("other_pe_reg0", r0(), 64'd10);
        check("other_pe_fwd", opt_out, op);
        op = mk_op(C_LD, 4'd5, 1'b1, 4'd0, 48'h55);
        send(op);
        check("bcast_reg0", r0(), 64'h55);
        check("bcast_fwd", opt_out, op);

        // Readback.
        send(mk_op(C_LD, 4'd0, 1'b0, 4'd1, 48'hABC));
        check("ld_abc", r1(), 64'hABC);
        op = mk_op(C_RD, 4'd0, 1'b0, 4'd1, 48'h0);
`ifdef SPMV_PE_CTRL_READBACK_EN
        exp = mk_op(C_RD, 4'd0, 1'b0, 4'd1, 48'hABC);
`else
        exp = op;
`endif
        send(op);
        check("rd_idx1", opt_out, exp);
        op = mk_op(C_RD, 4'd3, 1'b1, 4'd1, 48'h777);
        send(op);
        check("rd_bcast", opt_out, op);
        op = mk_op(C_RD, 4'd0, 1'b0, 4'd15, 48'h123);
`ifdef SPMV_PE_CTRL_READBACK_EN
        exp = mk_op(C_RD, 4'd0, 1'b0, 4'd15, 48'h0);
`else
        exp = op;
`endif
        send(op);
        check("rd_idx15", opt_out, exp);

        // Out-of-range LD is dropped.
        send(mk_op(C_LD, 4'd0, 1'b0, 4'd15, 48'h999));
        check("ld15_reg0", r0(), 64'h55);
        check("ld15_reg1", r1(), 64'hABC);

        // RST during STEADY with a concurrent step.
        send(mk_op(C_LD, 4'd0, 1'b0, 4'd0, 48'd0));
        send(mk_op(C_LD, 4'd0, 1'b0, 4'd1, 48'd100));
        send(mk_op(C_STEADY, 4'd0, 1'b0, 4'd0, 48'd0));
        check("steady_on2", 64'(steady), 64'h1);
        $display("txn opt_in=%h", mk_op(C_RST, 4'd0, 1'b0, 4'd0, 48'd0));
        opt_in = mk_op(C_RST, 4'd0, 1'b0, 4'd0, 48'd0);
        tick();
        opt_in  = '0;
        step_in = 1'b1;
        tick();
        step_in = 1'b0;
        check("rst_state", 64'(steady), 64'h0);
        check("rst_reg0", r0(), 64'h0);
        check("rst_reg1", r1(), 64'h0);
        check("rst_soft_on", 64'(soft_rst), 64'h1);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (soft_rst) pulses++;
            tick();
        end
        check("soft_len", 64'(pulses), 64'd4);

        // STEADY with reg0 == reg1 lasts exactly one cycle.
        send(mk_op(C_STEADY, 4'd0, 1'b0, 4'd0, 48'd0));
        check("eq_steady_on", 64'(steady), 64'h1);
        tick();
        check("eq_steady_off", 64'(steady), 64'h0);

        // Downstream busy propagates through the busy stage.
        tick();
        busy_in = 1'b1;
        tick();
        check("busy_in_hi", 64'(busy_out), 64'h1);
        busy_in = 1'b0;
        tick();
        check("busy_in_lo", 64'(busy_out), 64'h0);

        // Asynchronous reset between edges while in STEADY.
        send(mk_op(C_LD, 4'd0, 1'b0, 4'd1, 48'd5));
        send(mk_op(C_STEADY, 4'd0, 1'b0, 4'd0, 48'd0));
        opt_in = NOPD;
        tick();
        tick();
        check("pre_arst_opt", opt_out, NOPD);
        check("pre_arst_steady", 64'(steady), 64'h1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_opt", opt_out, 64'h0);
        check("arst_steady", 64'(steady), 64'h0);
        check("arst_reg1", r1(), 64'h0);
        check("arst_busy", 64'(busy_out), 64'h0);
        opt_in = '0;
        tick();
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
